// File: rtl/l2_pkg.sv
// Shared encodings for the L2 snoop responder: MESI states, snoop ops,
// snoop results and the responder FSM states.
package l2_pkg;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        OP_READ       = 2'b00,
        OP_WRITE      = 2'b01,
        OP_RWIM       = 2'b10,
        OP_INVALIDATE = 2'b11
    } snoop_op_e;

    typedef enum logic [1:0] {
        RES_NOHIT = 2'b00,
        RES_HIT   = 2'b01,
        RES_HITM  = 2'b10
    } snoop_res_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_UPDATE,
        ST_RESPOND
    } state_e;

endpackage

// File: rtl/snoop_mesi_table.sv
// Combinational snoop policy: maps (op, current MESI) to the new MESI state,
// bus result, write-back need, state-change flag and protocol error.
module snoop_mesi_table
    import l2_pkg::*;
(
    input  snoop_op_e  i_op,
    input  mesi_e      i_mesi,
    output mesi_e      o_next_mesi,
    output snoop_res_e o_result,
    output logic       o_need_wb,
    output logic       o_change,
    output logic       o_error
);

    always_comb begin
        o_next_mesi = i_mesi;
        o_result    = RES_NOHIT;
        o_need_wb   = 1'b0;
        o_error     = 1'b0;
        unique case (i_op)
            OP_READ: begin
                unique case (i_mesi)
                    MESI_M: begin o_next_mesi = MESI_S; o_result = RES_HITM; o_need_wb = 1'b1; end
                    MESI_E: begin o_next_mesi = MESI_S; o_result = RES_HIT; end
                    MESI_S: o_result = RES_HIT;
                    default: ;
                endcase
            end
            OP_RWIM: begin
                unique case (i_mesi)
                    MESI_M: begin o_next_mesi = MESI_I; o_result = RES_HITM; o_need_wb = 1'b1; end
                    MESI_E, MESI_S: begin o_next_mesi = MESI_I; o_result = RES_HIT; end
                    default: ;
                endcase
            end
            OP_INVALIDATE: begin
                unique case (i_mesi)
                    MESI_S: begin o_next_mesi = MESI_I; o_result = RES_HIT; end
                    // Another owner invalidating our exclusive copy is incoherent
                    MESI_E, MESI_M: o_error = 1'b1;
                    default: ;
                endcase
            end
            default: o_error = (i_mesi != MESI_I);
        endcase
        o_change = (o_next_mesi != i_mesi);
    end

endmodule

// File: rtl/l2_snoop_responder.sv
// L2 snoop responder: accepts bus snoops, looks up the tag store, writes back
// modified lines, updates MESI state and reports the snoop result.
// Define SNOOP_STATS_EN to add saturating result/error counters.
module l2_snoop_responder
    import l2_pkg::*;
#(
    parameter int indexBits = 14,
    parameter int tagBits   = 12,
    parameter int ways      = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         snoop_valid,
    input  logic [1:0]                   snoop_op,
    input  logic [tagBits+indexBits-1:0] snoop_addr,
    output logic                         snoop_ready,
    output logic                         lookup_req,
    output logic [indexBits-1:0]         lookup_index,
    output logic [tagBits-1:0]           lookup_tag,
    input  logic                         lookup_ack,
    input  logic                         lookup_hit,
    input  logic [$clog2(ways)-1:0]      lookup_way,
    input  logic [1:0]                   lookup_mesi,
    output logic                         update_en,
    output logic [indexBits-1:0]         update_index,
    output logic [$clog2(ways)-1:0]      update_way,
    output logic [1:0]                   update_mesi,
    output logic                         wb_req,
    input  logic                         wb_ack,
    output logic                         result_valid,
    output logic [1:0]                   snoop_result,
`ifdef SNOOP_STATS_EN
    output logic [15:0]                  hit_count,
    output logic [15:0]                  hitm_count,
    output logic [15:0]                  nohit_count,
    output logic [15:0]                  error_count,
`endif
    output logic                         protocol_error
);

    localparam int WW = $clog2(ways);

    state_e                 r_state, w_next;
    snoop_op_e              r_op;
    logic [indexBits-1:0]   r_index;
    logic [tagBits-1:0]     r_tag;
    logic [WW-1:0]          r_way;
    mesi_e                  r_next_mesi;
    snoop_res_e             r_result;
    logic                   r_error;

    mesi_e                  w_cur_mesi;
    mesi_e                  w_next_mesi;
    snoop_res_e             w_result;
    logic                   w_need_wb;
    logic                   w_change;
    logic                   w_error;

    // The table sees the live lookup response; its verdict is latched on lookup_ack
    assign w_cur_mesi = lookup_hit ? mesi_e'(lookup_mesi) : MESI_I;

    snoop_mesi_table u_table (
        .i_op        (r_op),
        .i_mesi      (w_cur_mesi),
        .o_next_mesi (w_next_mesi),
        .o_result    (w_result),
        .o_need_wb   (w_need_wb),
        .o_change    (w_change),
        .o_error     (w_error)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_index     <= '0;
            r_tag       <= '0;
            r_way       <= '0;
            r_next_mesi <= MESI_I;
            r_result    <= RES_NOHIT;
            r_error     <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && snoop_valid) begin
                r_op    <= snoop_op_e'(snoop_op);
                r_tag   <= snoop_addr[tagBits+indexBits-1:indexBits];
                r_index <= snoop_addr[indexBits-1:0];
            end
            if (r_state == ST_LOOKUP && lookup_ack) begin
                r_way       <= lookup_way;
                r_next_mesi <= w_next_mesi;
                r_result    <= w_result;
                r_error     <= w_error;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (snoop_valid) w_next = ST_LOOKUP;
            ST_LOOKUP: begin
                if (lookup_ack) begin
                    if (w_need_wb)     w_next = ST_WRITEBACK;
                    else if (w_change) w_next = ST_UPDATE;
                    else               w_next = ST_RESPOND;
                end
            end
            ST_WRITEBACK: if (wb_ack) w_next = ST_UPDATE;
            ST_UPDATE:    w_next = ST_RESPOND;
            ST_RESPOND:   w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    assign snoop_ready    = (r_state == ST_IDLE);
    assign lookup_req     = (r_state == ST_LOOKUP);
    assign lookup_index   = r_index;
    assign lookup_tag     = r_tag;
    assign wb_req         = (r_state == ST_WRITEBACK);
    assign update_en      = (r_state == ST_UPDATE);
    assign update_index   = r_index;
    assign update_way     = r_way;
    assign update_mesi    = r_next_mesi;
    assign result_valid   = (r_state == ST_RESPOND);
    assign snoop_result   = result_valid ? r_result : RES_NOHIT;
    assign protocol_error = result_valid && r_error;

`ifdef SNOOP_STATS_EN
    logic [15:0] r_hit_cnt, r_hitm_cnt, r_nohit_cnt, r_err_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hit_cnt   <= '0;
            r_hitm_cnt  <= '0;
            r_nohit_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (result_valid && r_result == RES_HIT && r_hit_cnt != '1)
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (result_valid && r_result == RES_HITM && r_hitm_cnt != '1)
                r_hitm_cnt <= r_hitm_cnt + 16'd1;
            if (result_valid && r_result == RES_NOHIT && r_nohit_cnt != '1)
                r_nohit_cnt <= r_nohit_cnt + 16'd1;
            if (protocol_error && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign hit_count   = r_hit_cnt;
    assign hitm_count  = r_hitm_cnt;
    assign nohit_count = r_nohit_cnt;
    assign error_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Directed bench for l2_snoop_responder: per-scenario tasks plus a
// scoreboard of expected {protocol_error, snoop_result} popped on result_valid.
module tb_l2_snoop_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        snoop_valid;
    logic [1:0]  snoop_op;
    logic [25:0] snoop_addr;
    logic        snoop_ready;
    logic        lookup_req;
    logic [13:0] lookup_index;
    logic [11:0] lookup_tag;
    logic        lookup_ack;
    logic        lookup_hit;
    logic [2:0]  lookup_way;
    logic [1:0]  lookup_mesi;
    logic        update_en;
    logic [13:0] update_index;
    logic [2:0]  update_way;
    logic [1:0]  update_mesi;
    logic        wb_req;
    logic        wb_ack;
    logic        result_valid;
    logic [1:0]  snoop_result;
    logic        protocol_error;
`ifdef SNOOP_STATS_EN
    logic [15:0] hit_count, hitm_count, nohit_count, error_count;
`endif

    int vectors = 0;
    int miscompares = 0;
    int exp_errs = 0;
    logic [2:0] sb_q[$];
    logic [2:0] sb_exp;

    always #5 clock = ~clock;

    l2_snoop_responder #(.indexBits(14), .tagBits(12), .ways(8)) dut (
        .clock(clock), .reset(reset),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .snoop_ready(snoop_ready),
        .lookup_req(lookup_req), .lookup_index(lookup_index), .lookup_tag(lookup_tag),
        .lookup_ack(lookup_ack), .lookup_hit(lookup_hit), .lookup_way(lookup_way),
        .lookup_mesi(lookup_mesi),
        .update_en(update_en), .update_index(update_index), .update_way(update_way),
        .update_mesi(update_mesi),
        .wb_req(wb_req), .wb_ack(wb_ack),
        .result_valid(result_valid), .snoop_result(snoop_result),
`ifdef SNOOP_STATS_EN
        .hit_count(hit_count), .hitm_count(hitm_count),
        .nohit_count(nohit_count), .error_count(error_count),
`endif
        .protocol_error(protocol_error)
    );

    // Result monitor: every result_valid must match the oldest expectation
    always @(negedge clock) begin
        if (!reset) begin
            vectors++;
            if (protocol_error && !result_valid) begin
                miscompares++;
                $display("FAIL stray_protocol_error got=1 want=0");
            end
            if (result_valid) begin
                vectors++;
                if (sb_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_result_valid got=1 want=0");
                end else begin
                    sb_exp = sb_q.pop_front();
                    if ({protocol_error, snoop_result} !== sb_exp) begin
                        miscompares++;
                        $display("FAIL result got err=%0b res=%b want err=%0b res=%b",
                                 protocol_error, snoop_result, sb_exp[2], sb_exp[1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        exp_errs = 0;
        @(negedge clock);
        vectors++;
        if (snoop_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready got=%b want=1", snoop_ready); end
        vectors++;
        if ({lookup_req, wb_req, update_en, result_valid, protocol_error} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_strobes got=%b want=00000",
                     {lookup_req, wb_req, update_en, result_valid, protocol_error});
        end
        vectors++;
        if ({lookup_index, lookup_tag, update_index, update_way, update_mesi, snoop_result} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses got=nonzero want=0");
        end
`ifdef SNOOP_STATS_EN
        vectors++;
        if ({hit_count, hitm_count, nohit_count, error_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_counters got=nonzero want=0");
        end
`endif
        @(posedge clock); #1;
    endtask

    task automatic run_op(input string name, input logic [1:0] op, input logic [25:0] addr,
                          input logic hit, input logic [1:0] mesi, input logic [2:0] way,
                          input int ack_delay, input int wb_delay,
                          input logic [1:0] exp_res, input logic exp_err,
                          input int exp_upd, input logic [1:0] exp_umesi,
                          input int exp_wb, input int exp_lat);
        int c = 1, lk = 0, wbc = 0, upd = 0, lat = 0;
        logic [1:0] got_umesi = 2'b00;
        logic accepted = 1'b0, bus_ok = 1'b1;
        snoop_valid = 1'b1; snoop_op = op; snoop_addr = addr;
        lookup_hit = hit; lookup_mesi = mesi; lookup_way = way;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (snoop_ready) begin accepted = 1'b1; break; end
        end
        vectors++;
        if (!accepted) begin
            miscompares++;
            $display("FAIL %s_accept got=0 want=1", name);
            snoop_valid = 1'b0;
            return;
        end
        sb_q.push_back({exp_err, exp_res});
        if (exp_err) exp_errs++;
        @(posedge clock); #1;
        snoop_valid = 1'b0; snoop_op = 2'b00; snoop_addr = '0;
        while (c < 60) begin
            lookup_ack = 1'b0; wb_ack = 1'b0;
            if (lookup_req) begin
                lk++;
                lookup_ack = (lk > ack_delay);
                if (lookup_tag !== addr[25:14] || lookup_index !== addr[13:0]) bus_ok = 1'b0;
            end
            if (wb_req) begin
                wbc++;
                wb_ack = (wbc >= wb_delay);
            end
            if (update_en) begin
                upd++;
                got_umesi = update_mesi;
                if (update_index !== addr[13:0] || update_way !== way) bus_ok = 1'b0;
            end
            if (result_valid) begin lat = c; break; end
            @(posedge clock); #1;
            c++;
        end
        lookup_ack = 1'b0; wb_ack = 1'b0;
        vectors++;
        if (lat !== exp_lat) begin miscompares++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, exp_lat); end
        vectors++;
        if (upd !== exp_upd) begin miscompares++; $display("FAIL %s_update_count got=%0d want=%0d", name, upd, exp_upd); end
        if (exp_upd > 0) begin
            vectors++;
            if (got_umesi !== exp_umesi) begin miscompares++; $display("FAIL %s_update_mesi got=%b want=%b", name, got_umesi, exp_umesi); end
        end
        vectors++;
        if (wbc !== exp_wb) begin miscompares++; $display("FAIL %s_wb_cycles got=%0d want=%0d", name, wbc, exp_wb); end
        vectors++;
        if (bus_ok !== 1'b1) begin miscompares++; $display("FAIL %s_index_tag_way got=wrong want=captured", name); end
        @(posedge clock); #1;
        vectors++;
        if (snoop_ready !== 1'b1) begin miscompares++; $display("FAIL %s_idle_after got=%b want=1", name, snoop_ready); end
    endtask

    task automatic test_read_m_writeback();
        run_op("read_m", 2'b00, {12'hA5C, 14'h1234}, 1'b1, 2'b11, 3'd5, 0, 3,
               2'b10, 1'b0, 1, 2'b01, 3, 6);
    endtask

    task automatic test_rwim_e();
        run_op("rwim_e", 2'b10, {12'h0F1, 14'h0042}, 1'b1, 2'b10, 3'd2, 0, 0,
               2'b01, 1'b0, 1, 2'b00, 0, 3);
    endtask

    task automatic test_read_miss();
        run_op("read_miss", 2'b00, {12'hFFF, 14'h3FFF}, 1'b0, 2'b11, 3'd7, 0, 0,
               2'b00, 1'b0, 0, 2'b00, 0, 2);
    endtask

    task automatic test_invalidate_m();
        run_op("inval_m", 2'b11, {12'h123, 14'h2AAA}, 1'b1, 2'b11, 3'd1, 0, 0,
               2'b00, 1'b1, 0, 2'b00, 0, 2);
`ifdef SNOOP_STATS_EN
        vectors++;
        if (error_count !== 16'(exp_errs)) begin
            miscompares++;
            $display("FAIL error_count got=%0d want=%0d", error_count, exp_errs);
        end
`endif
    endtask

    task automatic test_transitions();
        run_op("read_e",   2'b00, {12'h111, 14'h0001}, 1'b1, 2'b10, 3'd3, 0, 0, 2'b01, 1'b0, 1, 2'b01, 0, 3);
        run_op("read_s",   2'b00, {12'h222, 14'h0002}, 1'b1, 2'b01, 3'd4, 0, 0, 2'b01, 1'b0, 0, 2'b00, 0, 2);
        run_op("write_s",  2'b01, {12'h333, 14'h0003}, 1'b1, 2'b01, 3'd0, 0, 0, 2'b00, 1'b1, 0, 2'b00, 0, 2);
        run_op("write_mi", 2'b01, {12'h444, 14'h0004}, 1'b0, 2'b11, 3'd6, 0, 0, 2'b00, 1'b0, 0, 2'b00, 0, 2);
        run_op("inval_s",  2'b11, {12'h555, 14'h0005}, 1'b1, 2'b01, 3'd6, 0, 0, 2'b01, 1'b0, 1, 2'b00, 0, 3);
        run_op("inval_e",  2'b11, {12'h666, 14'h0006}, 1'b1, 2'b10, 3'd2, 0, 0, 2'b00, 1'b1, 0, 2'b00, 0, 2);
        run_op("rwim_m",   2'b10, {12'h777, 14'h0007}, 1'b1, 2'b11, 3'd3, 0, 1, 2'b10, 1'b0, 1, 2'b00, 1, 4);
        run_op("rwim_s",   2'b10, {12'h888, 14'h0008}, 1'b1, 2'b01, 3'd1, 0, 0, 2'b01, 1'b0, 1, 2'b00, 0, 3);
        run_op("slow_ack", 2'b00, {12'h999, 14'h0009}, 1'b0, 2'b00, 3'd0, 2, 0, 2'b00, 1'b0, 0, 2'b00, 0, 4);
    endtask

    task automatic test_reset_during_wb();
        int wbc = 0;
        snoop_valid = 1'b1; snoop_op = 2'b00; snoop_addr = {12'hBEE, 14'h0BAD};
        lookup_hit = 1'b1; lookup_mesi = 2'b11; lookup_way = 3'd4;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (snoop_ready) break;
        end
        @(posedge clock); #1;
        snoop_valid = 1'b0;
        for (int i = 0; i < 20 && wbc < 2; i++) begin
            lookup_ack = lookup_req;
            if (wb_req) wbc++;
            if (wbc < 2) begin @(posedge clock); #1; end
        end
        lookup_ack = 1'b0;
        vectors++;
        if (wbc !== 2) begin miscompares++; $display("FAIL rst_wb_reached got=%0d want=2", wbc); end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_errs = 0;
        vectors++;
        if (wb_req !== 1'b0) begin miscompares++; $display("FAIL rst_wb_req got=%b want=0", wb_req); end
        vectors++;
        if (snoop_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got=%b want=1", snoop_ready); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if ({update_en, result_valid, lookup_req, wb_req} !== 4'b0) begin
                miscompares++;
                $display("FAIL rst_abandon got=%b want=0000", {update_en, result_valid, lookup_req, wb_req});
            end
        end
`ifdef SNOOP_STATS_EN
        vectors++;
        if (error_count !== 16'd0) begin miscompares++; $display("FAIL rst_error_count got=%0d want=0", error_count); end
`endif
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        int hs = 0, results = 0;
        snoop_valid = 1'b1; snoop_op = 2'b00; snoop_addr = {12'h0AB, 14'h00CD};
        lookup_hit = 1'b0; lookup_mesi = 2'b00; lookup_way = 3'd0;
        for (int i = 0; i < 30 && results < 2; i++) begin
            if (hs >= 2) snoop_valid = 1'b0;
            lookup_ack = lookup_req;
            @(negedge clock);
            if (snoop_valid && snoop_ready) begin
                hs++;
                sb_q.push_back(3'b000);
            end
            if (result_valid) results++;
            if (lookup_req || result_valid) begin
                vectors++;
                if (snoop_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_busy got=%b want=0", snoop_ready); end
            end
            @(posedge clock); #1;
        end
        snoop_valid = 1'b0; lookup_ack = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (snoop_valid && snoop_ready) hs++;
        end
        vectors++;
        if (hs !== 2) begin miscompares++; $display("FAIL b2b_handshakes got=%0d want=2", hs); end
        vectors++;
        if (results !== 2) begin miscompares++; $display("FAIL b2b_results got=%0d want=2", results); end
        @(posedge clock); #1;
    endtask

    initial begin
        snoop_valid = 1'b0; snoop_op = 2'b00; snoop_addr = '0;
        lookup_ack = 1'b0; lookup_hit = 1'b0; lookup_way = 3'd0; lookup_mesi = 2'b00;
        wb_ack = 1'b0;
        test_reset();
        test_read_m_writeback();
        test_rwim_e();
        test_read_miss();
        test_invalidate_m();
        test_transitions();
        test_reset_during_wb();
        test_back_to_back();
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
